// File: rtl/juice_bottler.sv
// Bottles a 3-bit juice stream into CAP-unit bottles and queues {id, spill} records.
// Define JUICE_BOTTLER_SPILL_CARRY_EN to start each new bottle at the previous spill.
//
// state | meaning
// FILL  | accepting pours, integrating into level
// SEAL  | one cycle after a full bottle; push if the FIFO has room
// HOLD  | FIFO was full at seal time; wait for room, pours dropped
module juice_bottler #(
    parameter int CAP   = 16,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pour_en,
    input  logic [2:0] juice,
    output logic       busy,
    output logic [7:0] level,
    output logic       bottle_valid,
    input  logic       bottle_ready,
    output logic [7:0] bottle_id,
    output logic [2:0] bottle_spill
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [7:0]  CAP_L   = CAP[7:0];
    localparam logic [PW:0] DEPTH_L = DEPTH[PW:0];

    typedef enum logic [1:0] {FILL, SEAL, HOLD} state_t;

    state_t        state, state_nxt;
    logic [7:0]    level_nxt;
    logic [2:0]    spill, spill_nxt;
    logic [7:0]    id_cnt;
    logic [7:0]    sum;
    logic [7:0]    new_level;
    logic          push, pop, has_space;

    logic [10:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    assign sum       = level + {5'b0, juice};
    assign has_space = count < DEPTH_L;

`ifdef JUICE_BOTTLER_SPILL_CARRY_EN
    assign new_level = {5'b0, spill};
`else
    assign new_level = 8'd0;
`endif

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        spill_nxt = spill;
        push      = 1'b0;
        case (state)
            FILL: begin
                if (pour_en) begin
                    if (sum < CAP_L) begin
                        level_nxt = sum;
                    end else begin
                        spill_nxt = 3'(sum - CAP_L);
                        level_nxt = CAP_L;
                        state_nxt = SEAL;
                    end
                end
            end
            SEAL, HOLD: begin
                // eligibility uses the start-of-cycle count, so a same-edge pop cannot unblock a full FIFO
                if (has_space) begin
                    push      = 1'b1;
                    level_nxt = new_level;
                    state_nxt = FILL;
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            level  <= 8'd0;
            spill  <= 3'd0;
            id_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            spill <= spill_nxt;
            if (push) id_cnt <= id_cnt + 8'd1;
        end
    end

    assign busy = (state != FILL);

    assign bottle_valid = (count != '0);
    assign pop          = bottle_valid && bottle_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {id_cnt, spill};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign bottle_id    = bottle_valid ? mem[rd_ptr][10:3] : 8'd0;
    assign bottle_spill = bottle_valid ? mem[rd_ptr][2:0]  : 3'd0;

endmodule

// File: tb/tb_juice_bottler.sv
// Randomized bench for juice_bottler against a queue-based bottling model.
module tb_juice_bottler;
    localparam int CAP   = 16;
    localparam int DEPTH = 4;
`ifdef JUICE_BOTTLER_SPILL_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pour_en, bottle_ready;
    logic [2:0] juice;
    logic       busy, bottle_valid;
    logic [7:0] level, bottle_id;
    logic [2:0] bottle_spill;

    logic       p14, r14;
    logic [2:0] j14;
    logic       busy14, valid14;
    logic [7:0] level14, id14;
    logic [2:0] spill14;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    juice_bottler #(.CAP(CAP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pour_en(pour_en), .juice(juice), .busy(busy),
        .level(level), .bottle_valid(bottle_valid), .bottle_ready(bottle_ready),
        .bottle_id(bottle_id), .bottle_spill(bottle_spill)
    );

    juice_bottler #(.CAP(14), .DEPTH(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .pour_en(p14), .juice(j14), .busy(busy14),
        .level(level14), .bottle_valid(valid14), .bottle_ready(r14),
        .bottle_id(id14), .bottle_spill(spill14)
    );

    // Reference model: a bottle is either filling or waiting to be queued.
    int m_level, m_spill, m_id, m_pushes;
    bit m_pend;
    int q_id[$];
    int q_sp[$];

    function automatic void model_reset();
        m_level = 0; m_spill = 0; m_id = 0; m_pend = 0; m_pushes = 0;
        q_id.delete(); q_sp.delete();
    endfunction

    function automatic void model_step();
        int  n;
        bit  do_pop, do_push;
        int  s;
        n       = q_id.size();
        do_pop  = (n != 0) && bottle_ready;
        do_push = 1'b0;
        if (m_pend) begin
            if (n < DEPTH) do_push = 1'b1;
        end else if (pour_en) begin
            s = m_level + int'(juice);
            if (s < CAP) begin
                m_level = s;
            end else begin
                m_spill = s - CAP;
                m_level = CAP;
                m_pend  = 1'b1;
            end
        end
        if (do_pop) begin
            void'(q_id.pop_front());
            void'(q_sp.pop_front());
        end
        if (do_push) begin
            q_id.push_back(m_id);
            q_sp.push_back(m_spill);
            m_id     = (m_id + 1) % 256;
            m_pushes = m_pushes + 1;
            m_level  = CARRY ? m_spill : 0;
            m_pend   = 1'b0;
        end
    endfunction

    function automatic logic [20:0] model_out();
        logic [7:0] eid;
        logic [2:0] esp;
        eid = (q_id.size() != 0) ? 8'(q_id[0]) : 8'd0;
        esp = (q_sp.size() != 0) ? 3'(q_sp[0]) : 3'd0;
        return {m_pend, 8'(m_level), q_id.size() != 0, eid, esp};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        pour_en = 0; juice = 0; bottle_ready = 0; p14 = 0; j14 = 0; r14 = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (level !== 8'd0) $display("FAIL reset_level: got %0d expected 0", level); else passed++;
        total++; if (bottle_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bottle_valid); else passed++;
        total++; if (bottle_id !== 8'd0) $display("FAIL reset_id: got %0d expected 0", bottle_id); else passed++;
        total++; if (bottle_spill !== 3'd0) $display("FAIL reset_spill: got %0d expected 0", bottle_spill); else passed++;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_cap14();
        p14 = 1; j14 = 7; r14 = 1;
        tick();
        total++; if (level14 !== 8'd7) $display("FAIL cap14_level1: got %0d expected 7", level14); else passed++;
        tick();
        p14 = 0;
        total++; if ({busy14, level14} !== {1'b1, 8'd14}) $display("FAIL cap14_seal: got busy=%b level=%0d expected busy=1 level=14", busy14, level14); else passed++;
        tick();
        total++; if ({valid14, id14, spill14, busy14, level14} !== {1'b1, 8'd0, 3'd0, 1'b0, 8'd0})
            $display("FAIL cap14_record: got v=%b id=%0d sp=%0d busy=%b lvl=%0d expected v=1 id=0 sp=0 busy=0 lvl=0",
                     valid14, id14, spill14, busy14, level14);
        else passed++;
    endtask

    task automatic test_fill_sequence();
        int busy_cyc = -1;
        int valid_cyc = -1;
        logic [20:0] exp;
        pour_en = 1; juice = 3; bottle_ready = 1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            exp = model_out();
            total++;
            if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== exp)
                $display("FAIL fill_seq cycle %0d: got %h expected %h", c, {busy, level, bottle_valid, bottle_id, bottle_spill}, exp);
            else passed++;
            if (busy && busy_cyc < 0) busy_cyc = c;
            if (bottle_valid && valid_cyc < 0) begin
                valid_cyc = c;
                total++;
                if ({bottle_id, bottle_spill} !== {8'd0, 3'd2})
                    $display("FAIL first_record: got id=%0d sp=%0d expected id=0 sp=2", bottle_id, bottle_spill);
                else passed++;
            end
        end
        total++;
        if (busy_cyc != 6 || valid_cyc != 7)
            $display("FAIL seal_latency: got busy@%0d valid@%0d expected busy@6 valid@7", busy_cyc, valid_cyc);
        else passed++;
    endtask

    task automatic test_backpressure();
        int guard = 0;
        logic [20:0] exp;
        bottle_ready = 0; pour_en = 1; juice = 5;
        while (!(q_id.size() == DEPTH && m_pend) && guard < 100) begin
            tick(); guard++;
            exp = model_out();
            total++;
            if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== exp)
                $display("FAIL backpressure_fill: got %h expected %h", {busy, level, bottle_valid, bottle_id, bottle_spill}, exp);
            else passed++;
        end
        repeat (3) tick();
        total++;
        if ({busy, level} !== {1'b1, 8'(CAP)})
            $display("FAIL hold_drops_pours: got busy=%b level=%0d expected busy=1 level=%0d", busy, level, CAP);
        else passed++;
        bottle_ready = 1;
        tick();
        bottle_ready = 0;
        exp = model_out();
        total++;
        if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== exp)
            $display("FAIL hold_pop: got %h expected %h", {busy, level, bottle_valid, bottle_id, bottle_spill}, exp);
        else passed++;
        tick();
        exp = model_out();
        total++;
        if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== exp || busy !== 1'b0)
            $display("FAIL hold_release: got %h expected %h", {busy, level, bottle_valid, bottle_id, bottle_spill}, exp);
        else passed++;
    endtask

    task automatic test_same_cycle();
        int guard = 0;
        logic [20:0] exp;
        pour_en = 0; bottle_ready = 1;
        repeat (DEPTH + 2) tick();
        bottle_ready = 0; pour_en = 1; juice = 7;
        while (!(q_id.size() == 2 && m_pend) && guard < 60) begin
            tick(); guard++;
        end
        total++;
        if (guard >= 60) $display("FAIL same_cycle_setup: got timeout expected 2 queued"); else passed++;
        bottle_ready = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            exp = model_out();
            total++;
            if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== exp)
                $display("FAIL same_cycle cycle %0d: got %h expected %h", c, {busy, level, bottle_valid, bottle_id, bottle_spill}, exp);
            else passed++;
        end
    endtask

    task automatic test_id_wrap();
        int start, guard;
        logic [20:0] exp;
        start = m_pushes; guard = 0;
        pour_en = 1; juice = 7; bottle_ready = 1;
        while (m_pushes < start + 258 && guard < 3000) begin
            tick(); guard++;
            exp = model_out();
            total++;
            if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== exp)
                $display("FAIL id_wrap: got %h expected %h", {busy, level, bottle_valid, bottle_id, bottle_spill}, exp);
            else passed++;
        end
        total++;
        if (guard >= 3000) $display("FAIL id_wrap_timeout: got %0d bottles expected 258", m_pushes - start); else passed++;
    endtask

    task automatic test_random();
        logic [20:0] exp;
        for (int c = 0; c < 1500; c++) begin
            pour_en = 1'($urandom_range(0, 3) != 0);
            juice = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) bottle_ready = ~bottle_ready;
            tick();
            exp = model_out();
            total++;
            if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== exp)
                $display("FAIL random cycle %0d: got %h expected %h", c, {busy, level, bottle_valid, bottle_id, bottle_spill}, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_in_hold();
        int guard = 0;
        bit seen = 0;
        logic [20:0] exp;
        bottle_ready = 0; pour_en = 1; juice = 7;
        while (!(q_id.size() == DEPTH && m_pend) && guard < 100) begin
            tick(); guard++;
        end
        tick();
        total++;
        if (busy !== 1'b1 || bottle_valid !== 1'b1) $display("FAIL hold_before_reset: got busy=%b valid=%b expected 1 1", busy, bottle_valid); else passed++;
        #2 rst_n = 0;
        #1;
        total++;
        if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== 21'd0)
            $display("FAIL async_reset: got %h expected 0", {busy, level, bottle_valid, bottle_id, bottle_spill});
        else passed++;
        pour_en = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        pour_en = 1; bottle_ready = 1; guard = 0;
        while (!seen && guard < 20) begin
            tick(); guard++;
            exp = model_out();
            total++;
            if ({busy, level, bottle_valid, bottle_id, bottle_spill} !== exp)
                $display("FAIL after_reset: got %h expected %h", {busy, level, bottle_valid, bottle_id, bottle_spill}, exp);
            else passed++;
            if (bottle_valid) begin
                seen = 1;
                total++;
                if (bottle_id !== 8'd0) $display("FAIL first_id_after_reset: got %0d expected 0", bottle_id); else passed++;
            end
        end
        total++;
        if (!seen) $display("FAIL after_reset_timeout: got no record expected id 0"); else passed++;
    endtask

    initial begin
        test_reset();
        test_cap14();
        test_fill_sequence();
        test_backpressure();
        test_same_cycle();
        test_id_wrap();
        test_random();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
